// File: rtl/sms4_round_f.sv
// sms4_round_f: one SMS4 round, x4 = x0 ^ L(tau(x1 ^ x2 ^ x3 ^ rk)).
// A single S-box is shared over the four bytes, byte 0 first.
// Timing: the accepting edge, then 4 substitution cycles, then 1 linear-transform cycle.
// Optional feature: define SMS4_KEY_MODE_EN to add the key_mode port.
// With key_mode=1 the block applies the key-expansion transform L'.
// Without the macro, the cipher transform L is always used and latency is unchanged.

// Combinational SMS4 S-box; byte in, byte out.
module sms4_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Table lookup of the fixed SMS4 substitution.
  always_comb begin
    y = 8'h00;
    case (a)
      8'h00: y = 8'hd6; 8'h01: y = 8'h90; 8'h02: y = 8'he9; 8'h03: y = 8'hfe;
      8'h04: y = 8'hcc; 8'h05: y = 8'he1; 8'h06: y = 8'h3d; 8'h07: y = 8'hb7;
      8'h08: y = 8'h16; 8'h09: y = 8'hb6; 8'h0a: y = 8'h14; 8'h0b: y = 8'hc2;
      8'h0c: y = 8'h28; 8'h0d: y = 8'hfb; 8'h0e: y = 8'h2c; 8'h0f: y = 8'h05;
      8'h10: y = 8'h2b; 8'h11: y = 8'h67; 8'h12: y = 8'h9a; 8'h13: y = 8'h76;
      8'h14: y = 8'h2a; 8'h15: y = 8'hbe; 8'h16: y = 8'h04; 8'h17: y = 8'hc3;
      8'h18: y = 8'haa; 8'h19: y = 8'h44; 8'h1a: y = 8'h13; 8'h1b: y = 8'h26;
      8'h1c: y = 8'h49; 8'h1d: y = 8'h86; 8'h1e: y = 8'h06; 8'h1f: y = 8'h99;
      8'h20: y = 8'h9c; 8'h21: y = 8'h42; 8'h22: y = 8'h50; 8'h23: y = 8'hf4;
      8'h24: y = 8'h91; 8'h25: y = 8'hef; 8'h26: y = 8'h98; 8'h27: y = 8'h7a;
      8'h28: y = 8'h33; 8'h29: y = 8'h54; 8'h2a: y = 8'h0b; 8'h2b: y = 8'h43;
      8'h2c: y = 8'hed; 8'h2d: y = 8'hcf; 8'h2e: y = 8'hac; 8'h2f: y = 8'h62;
      8'h30: y = 8'he4; 8'h31: y = 8'hb3; 8'h32: y = 8'h1c; 8'h33: y = 8'ha9;
      8'h34: y = 8'hc9; 8'h35: y = 8'h08; 8'h36: y = 8'he8; 8'h37: y = 8'h95;
      8'h38: y = 8'h80; 8'h39: y = 8'hdf; 8'h3a: y = 8'h94; 8'h3b: y = 8'hfa;
      8'h3c: y = 8'h75; 8'h3d: y = 8'h8f; 8'h3e: y = 8'h3f; 8'h3f: y = 8'ha6;
      8'h40: y = 8'h47; 8'h41: y = 8'h07; 8'h42: y = 8'ha7; 8'h43: y = 8'hfc;
      8'h44: y = 8'hf3; 8'h45: y = 8'h73; 8'h46: y = 8'h17; 8'h47: y = 8'hba;
      8'h48: y = 8'h83; 8'h49: y = 8'h59; 8'h4a: y = 8'h3c; 8'h4b: y = 8'h19;
      8'h4c: y = 8'he6; 8'h4d: y = 8'h85; 8'h4e: y = 8'h4f; 8'h4f: y = 8'ha8;
      8'h50: y = 8'h68; 8'h51: y = 8'h6b; 8'h52: y = 8'h81; 8'h53: y = 8'hb2;
      8'h54: y = 8'h71; 8'h55: y = 8'h64; 8'h56: y = 8'hda; 8'h57: y = 8'h8b;
      8'h58: y = 8'hf8; 8'h59: y = 8'heb; 8'h5a: y = 8'h0f; 8'h5b: y = 8'h4b;
      8'h5c: y = 8'h70; 8'h5d: y = 8'h56; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h35;
      8'h60: y = 8'h1e; 8'h61: y = 8'h24; 8'h62: y = 8'h0e; 8'h63: y = 8'h5e;
      8'h64: y = 8'h63; 8'h65: y = 8'h58; 8'h66: y = 8'hd1; 8'h67: y = 8'ha2;
      8'h68: y = 8'h25; 8'h69: y = 8'h22; 8'h6a: y = 8'h7c; 8'h6b: y = 8'h3b;
      8'h6c: y = 8'h01; 8'h6d: y = 8'h21; 8'h6e: y = 8'h78; 8'h6f: y = 8'h87;
      8'h70: y = 8'hd4; 8'h71: y = 8'h00; 8'h72: y = 8'h46; 8'h73: y = 8'h57;
      8'h74: y = 8'h9f; 8'h75: y = 8'hd3; 8'h76: y = 8'h27; 8'h77: y = 8'h52;
      8'h78: y = 8'h4c; 8'h79: y = 8'h36; 8'h7a: y = 8'h02; 8'h7b: y = 8'he7;
      8'h7c: y = 8'ha0; 8'h7d: y = 8'hc4; 8'h7e: y = 8'hc8; 8'h7f: y = 8'h9e;
      8'h80: y = 8'hea; 8'h81: y = 8'hbf; 8'h82: y = 8'h8a; 8'h83: y = 8'hd2;
      8'h84: y = 8'h40; 8'h85: y = 8'hc7; 8'h86: y = 8'h38; 8'h87: y = 8'hb5;
      8'h88: y = 8'ha3; 8'h89: y = 8'hf7; 8'h8a: y = 8'hf2; 8'h8b: y = 8'hce;
      8'h8c: y = 8'hf9; 8'h8d: y = 8'h61; 8'h8e: y = 8'h15; 8'h8f: y = 8'ha1;
      8'h90: y = 8'he0; 8'h91: y = 8'hae; 8'h92: y = 8'h5d; 8'h93: y = 8'ha4;
      8'h94: y = 8'h9b; 8'h95: y = 8'h34; 8'h96: y = 8'h1a; 8'h97: y = 8'h55;
      8'h98: y = 8'had; 8'h99: y = 8'h93; 8'h9a: y = 8'h32; 8'h9b: y = 8'h30;
      8'h9c: y = 8'hf5; 8'h9d: y = 8'h8c; 8'h9e: y = 8'hb1; 8'h9f: y = 8'he3;
      8'ha0: y = 8'h1d; 8'ha1: y = 8'hf6; 8'ha2: y = 8'he2; 8'ha3: y = 8'h2e;
      8'ha4: y = 8'h82; 8'ha5: y = 8'h66; 8'ha6: y = 8'hca; 8'ha7: y = 8'h60;
      8'ha8: y = 8'hc0; 8'ha9: y = 8'h29; 8'haa: y = 8'h23; 8'hab: y = 8'hab;
      8'hac: y = 8'h0d; 8'had: y = 8'h53; 8'hae: y = 8'h4e; 8'haf: y = 8'h6f;
      8'hb0: y = 8'hd5; 8'hb1: y = 8'hdb; 8'hb2: y = 8'h37; 8'hb3: y = 8'h45;
      8'hb4: y = 8'hde; 8'hb5: y = 8'hfd; 8'hb6: y = 8'h8e; 8'hb7: y = 8'h2f;
      8'hb8: y = 8'h03; 8'hb9: y = 8'hff; 8'hba: y = 8'h6a; 8'hbb: y = 8'h72;
      8'hbc: y = 8'h6d; 8'hbd: y = 8'h6c; 8'hbe: y = 8'h5b; 8'hbf: y = 8'h51;
      8'hc0: y = 8'h8d; 8'hc1: y = 8'h1b; 8'hc2: y = 8'haf; 8'hc3: y = 8'h92;
      8'hc4: y = 8'hbb; 8'hc5: y = 8'hdd; 8'hc6: y = 8'hbc; 8'hc7: y = 8'h7f;
      8'hc8: y = 8'h11; 8'hc9: y = 8'hd9; 8'hca: y = 8'h5c; 8'hcb: y = 8'h41;
      8'hcc: y = 8'h1f; 8'hcd: y = 8'h10; 8'hce: y = 8'h5a; 8'hcf: y = 8'hd8;
      8'hd0: y = 8'h0a; 8'hd1: y = 8'hc1; 8'hd2: y = 8'h31; 8'hd3: y = 8'h88;
      8'hd4: y = 8'ha5; 8'hd5: y = 8'hcd; 8'hd6: y = 8'h7b; 8'hd7: y = 8'hbd;
      8'hd8: y = 8'h2d; 8'hd9: y = 8'h74; 8'hda: y = 8'hd0; 8'hdb: y = 8'h12;
      8'hdc: y = 8'hb8; 8'hdd: y = 8'he5; 8'hde: y = 8'hb4; 8'hdf: y = 8'hb0;
      8'he0: y = 8'h89; 8'he1: y = 8'h69; 8'he2: y = 8'h97; 8'he3: y = 8'h4a;
      8'he4: y = 8'h0c; 8'he5: y = 8'h96; 8'he6: y = 8'h77; 8'he7: y = 8'h7e;
      8'he8: y = 8'h65; 8'he9: y = 8'hb9; 8'hea: y = 8'hf1; 8'heb: y = 8'h09;
      8'hec: y = 8'hc5; 8'hed: y = 8'h6e; 8'hee: y = 8'hc6; 8'hef: y = 8'h84;
      8'hf0: y = 8'h18; 8'hf1: y = 8'hf0; 8'hf2: y = 8'h7d; 8'hf3: y = 8'hec;
      8'hf4: y = 8'h3a; 8'hf5: y = 8'hdc; 8'hf6: y = 8'h4d; 8'hf7: y = 8'h20;
      8'hf8: y = 8'h79; 8'hf9: y = 8'hee; 8'hfa: y = 8'h5f; 8'hfb: y = 8'h3e;
      8'hfc: y = 8'hd7; 8'hfd: y = 8'hcb; 8'hfe: y = 8'h39; 8'hff: y = 8'h48;
      default: y = 8'h00;
    endcase
  end

endmodule

// State | meaning
// IDLE  | waiting for an input set; in_ready=1
// SUB   | one byte through the shared S-box per cycle, byte 0 first
// LIN   | apply L (or L'), xor with x0, load x4
// DONE  | result held with out_valid=1 until out_ready
module sms4_round_f (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:31] x0,
  input  logic [0:31] x1,
  input  logic [0:31] x2,
  input  logic [0:31] x3,
  input  logic [0:31] rk,
`ifdef SMS4_KEY_MODE_EN
  input  logic        key_mode,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] x4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    LIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [0:31] x0_q, x0_d;
  logic [0:31] xw_q, xw_d;
  logic [0:31] sub_q, sub_d;
  logic [0:31] x4_q, x4_d;
  logic        out_valid_q, out_valid_d;
  logic        mode_q, mode_d;
  logic        mode_in;

  logic [7:0]  sb_in;
  logic [7:0]  sb_out;
  logic [0:31] lin_l;
  logic [0:31] lin_k;

  sms4_sbox u_sbox (
    .a (sb_in),
    .y (sb_out)
  );

`ifdef SMS4_KEY_MODE_EN
  assign mode_in = key_mode;
`else
  assign mode_in = 1'b0;
`endif

  // Pick the byte of the xor word that the S-box works on this cycle.
  always_comb begin
    sb_in = xw_q[0:7];
    case (idx_q)
      2'd0: sb_in = xw_q[0:7];
      2'd1: sb_in = xw_q[8:15];
      2'd2: sb_in = xw_q[16:23];
      2'd3: sb_in = xw_q[24:31];
      default: sb_in = xw_q[0:7];
    endcase
  end

  // Both linear transforms; bit 0 is the MSB, so a left rotate moves low indices to the end.
  always_comb begin
    lin_l = sub_q
          ^ {sub_q[2:31],  sub_q[0:1]}
          ^ {sub_q[10:31], sub_q[0:9]}
          ^ {sub_q[18:31], sub_q[0:17]}
          ^ {sub_q[24:31], sub_q[0:23]};
    lin_k = sub_q
          ^ {sub_q[13:31], sub_q[0:12]}
          ^ {sub_q[23:31], sub_q[0:22]};
  end

  // Next-state and datapath updates for the round sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x0_d        = x0_q;
    xw_d        = xw_q;
    sub_d       = sub_q;
    x4_d        = x4_q;
    out_valid_d = out_valid_q;
    mode_d      = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x0_d    = x0;
          xw_d    = x1 ^ x2 ^ x3 ^ rk;
          mode_d  = mode_in;
          sub_d   = '0;
          idx_d   = 2'd0;
          state_d = SUB;
        end
      end
      SUB: begin
        case (idx_q)
          2'd0: sub_d[0:7]   = sb_out;
          2'd1: sub_d[8:15]  = sb_out;
          2'd2: sub_d[16:23] = sb_out;
          2'd3: sub_d[24:31] = sb_out;
          default: sub_d = sub_q;
        endcase
        // Index wraps 3 -> 0 as the FSM leaves SUB.
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = LIN;
        end
      end
      LIN: begin
        x4_d        = x0_q ^ (mode_q ? lin_k : lin_l);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register update; synchronous reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      x0_q        <= '0;
      xw_q        <= '0;
      sub_q       <= '0;
      x4_q        <= '0;
      out_valid_q <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x0_q        <= x0_d;
      xw_q        <= xw_d;
      sub_q       <= sub_d;
      x4_q        <= x4_d;
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign x4        = x4_q;

endmodule

// File: tb/tb_sms4_round_f.sv
// Directed bench for sms4_round_f. The key-mode vectors are exercised when SMS4_KEY_MODE_EN is defined.
module tb_sms4_round_f;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0, rk = '0;
  logic [31:0] x4;
`ifdef SMS4_KEY_MODE_EN
  logic        key_mode = 1'b0;
`endif

  int nchecks = 0;
  int nerr = 0;

  // Reference S-box as one packed table, row 0 first.
  logic [0:2047] sb_tbl = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

  always #5 clk = ~clk;

  sms4_round_f dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .rk        (rk),
`ifdef SMS4_KEY_MODE_EN
    .key_mode  (key_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x4        (x4)
  );

  function automatic logic [7:0] sb(input logic [7:0] v);
    return sb_tbl[{v, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] a0, a1, a2, a3, k, input logic m);
    logic [31:0] b, t;
    b = a1 ^ a2 ^ a3 ^ k;
    t = {sb(b[31:24]), sb(b[23:16]), sb(b[15:8]), sb(b[7:0])};
    if (m) return a0 ^ t ^ rotl(t, 13) ^ rotl(t, 23);
    return a0 ^ t ^ rotl(t, 2) ^ rotl(t, 10) ^ rotl(t, 18) ^ rotl(t, 24);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a0, a1, a2, a3, k, input logic m);
    x0 = a0; x1 = a1; x2 = a2; x3 = a3; rk = k;
`ifdef SMS4_KEY_MODE_EN
    key_mode = m;
`else
    if (m) $display("note: key mode vector skipped in this build");
`endif
  endtask

  // Accept one vector, check latency and result, then release it.
  task automatic do_op(input logic [31:0] a0, a1, a2, a3, k, input logic m,
                       input logic [31:0] exp, input string tag);
    int n;
    drive(a0, a1, a2, a3, k, m);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    nchecks++;
    if (n !== 6) begin nerr++; $error("FAIL %s latency: observed %0d expected %0d", tag, n, 6); end
    nchecks++;
    if (x4 !== exp) begin nerr++; $error("FAIL %s x4: observed %h expected %h", tag, x4, exp); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    nchecks++;
    if (out_valid !== 1'b0) begin nerr++; $error("FAIL %s release: observed %h expected %h", tag, out_valid, 1'b0); end
    nchecks++;
    if (in_ready !== 1'b1) begin nerr++; $error("FAIL %s idle: observed %h expected %h", tag, in_ready, 1'b1); end
  endtask

  initial begin
    logic [31:0] held;
    logic        acc;
    int          n;
    int          cyc;
    int          last_t;
    int          results;
    logic [31:0] q[$];

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    nchecks++;
    if (in_ready !== 1'b1) begin nerr++; $error("FAIL reset in_ready: observed %h expected %h", in_ready, 1'b1); end
    nchecks++;
    if (out_valid !== 1'b0) begin nerr++; $error("FAIL reset out_valid: observed %h expected %h", out_valid, 1'b0); end
    nchecks++;
    if (x4 !== 32'h0) begin nerr++; $error("FAIL reset x4: observed %h expected %h", x4, 32'h0); end
    rst = 1'b0;

    // Standard vector, accepted on the first edge after reset release
    do_op(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210, 32'hf12186f9, 1'b0,
          32'h27fad345, "std");

    // All-zero vector
    do_op(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h5b5b5b5b, "zero");

`ifdef SMS4_KEY_MODE_EN
    do_op(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h67676767, "zero key");
    // First key-expansion step: K0..K3 = MK ^ FK, CK0 = 00070e15 gives rk0
    do_op(32'ha292ffa1, 32'hdf01febf, 32'h99a12b0f, 32'hc42410cc, 32'h00070e15, 1'b1,
          32'hf12186f9, "rk0 key");
`endif

    // Backpressure: hold DONE for 10 cycles while in_valid is pulsed with other data
    drive(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210, 32'hf12186f9, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    nchecks++;
    if (n !== 6) begin nerr++; $error("FAIL bp latency: observed %0d expected %0d", n, 6); end
    held = x4;
    nchecks++;
    if (held !== 32'h27fad345) begin nerr++; $error("FAIL bp x4: observed %h expected %h", held, 32'h27fad345); end
    drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      tick();
      nchecks++;
      if (x4 !== 32'h27fad345) begin nerr++; $error("FAIL bp hold x4: observed %h expected %h", x4, 32'h27fad345); end
      nchecks++;
      if (out_valid !== 1'b1) begin nerr++; $error("FAIL bp hold valid: observed %h expected %h", out_valid, 1'b1); end
      nchecks++;
      if (in_ready !== 1'b0) begin nerr++; $error("FAIL bp hold ready: observed %h expected %h", in_ready, 1'b0); end
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    nchecks++;
    if (out_valid !== 1'b0) begin nerr++; $error("FAIL bp to idle valid: observed %h expected %h", out_valid, 1'b0); end
    nchecks++;
    if (in_ready !== 1'b1) begin nerr++; $error("FAIL bp to idle ready: observed %h expected %h", in_ready, 1'b1); end
    tick();
    in_valid = 1'b0;
    nchecks++;
    if (in_ready !== 1'b0) begin nerr++; $error("FAIL bp next accepted: observed %h expected %h", in_ready, 1'b0); end
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    nchecks++;
    if (n !== 6) begin nerr++; $error("FAIL bp next latency: observed %0d expected %0d", n, 6); end
    nchecks++;
    if (x4 !== 32'h5b5b5b5b) begin nerr++; $error("FAIL bp next x4: observed %h expected %h", x4, 32'h5b5b5b5b); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Inputs change during SUB; in_valid pulses in SUB and DONE are ignored
    drive(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210, 32'hf12186f9, 1'b0);
    in_valid = 1'b1;
    tick();
    x1 = 32'hdeadbeef;
    rk = 32'h13579bdf;
    x0 = 32'hffffffff;
    tick();
    in_valid = 1'b0;
    x1 = 32'h0badf00d;
    tick();
    in_valid = 1'b1;
    rk = 32'h2468ace0;
    tick();
    in_valid = 1'b0;
    n = 4;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    nchecks++;
    if (n !== 6) begin nerr++; $error("FAIL chg latency: observed %0d expected %0d", n, 6); end
    nchecks++;
    if (x4 !== 32'h27fad345) begin nerr++; $error("FAIL chg x4: observed %h expected %h", x4, 32'h27fad345); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      nchecks++;
      if (out_valid !== 1'b0) begin nerr++; $error("FAIL no buffered op: observed %h expected %h", out_valid, 1'b0); end
    end

    // Reset during the third SUB cycle
    drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nchecks++;
    if (out_valid !== 1'b0) begin nerr++; $error("FAIL midrst out_valid: observed %h expected %h", out_valid, 1'b0); end
    nchecks++;
    if (in_ready !== 1'b1) begin nerr++; $error("FAIL midrst in_ready: observed %h expected %h", in_ready, 1'b1); end
    nchecks++;
    if (x4 !== 32'h0) begin nerr++; $error("FAIL midrst x4: observed %h expected %h", x4, 32'h0); end
    do_op(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210, 32'hf12186f9, 1'b0,
          32'h27fad345, "after rst");

    // Back-to-back with in_valid held and out_ready tied high
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive($urandom, $urandom, $urandom, $urandom, $urandom, 1'b0);
    cyc = 0;
    last_t = -1;
    results = 0;
    for (int c = 0; c < 60; c++) begin
      acc = in_ready;
      if (acc) q.push_back(golden(x0, x1, x2, x3, rk, 1'b0));
      tick();
      cyc++;
      if (acc) drive($urandom, $urandom, $urandom, $urandom, $urandom, 1'b0);
      if (out_valid === 1'b1) begin
        if (q.size() > 0) begin
          held = q.pop_front();
          nchecks++;
          if (x4 !== held) begin nerr++; $error("FAIL b2b x4: observed %h expected %h", x4, held); end
        end else begin
          nchecks++;
          if (out_valid !== 1'b0) begin nerr++; $error("FAIL b2b unexpected result: observed %h expected %h", out_valid, 1'b0); end
        end
        if (last_t >= 0) begin
          nchecks++;
          if ((cyc - last_t) !== 7) begin nerr++; $error("FAIL b2b period: observed %0d expected %0d", cyc - last_t, 7); end
        end
        last_t = cyc;
        results++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    nchecks++;
    if (results !== 8) begin nerr++; $error("FAIL b2b result count: observed %0d expected %0d", results, 8); end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sms4_round_f.md
SMS4_ROUND_F -- requirements
Module: sms4_round_f

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: input word set valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a new input set.
REQ-005 SHALL have ports x0, x1, x2, x3, input, [0:31] each: round state words; bit 0 is the MSB.
REQ-006 SHALL have port rk, input, [0:31]: round key, or CK constant in key mode.
REQ-007 SHALL have port key_mode, input, 1 bit: 0 selects cipher L, 1 selects key-expansion L'; present only with SMS4_KEY_MODE_EN (REQ-027).
REQ-008 SHALL have port out_valid, output, 1 bit: result valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 SHALL have port x4, output, [0:31]: round result.

Function
REQ-011 SHALL compute x4 = x0 ^ L(tau(x1 ^ x2 ^ x3 ^ rk)).
- tau: byte-wise S-box substitution; byte 0 = bits [0:7].
- L(B) = B ^ rol(B,2) ^ rol(B,10) ^ rol(B,18) ^ rol(B,24).
- L'(B) = B ^ rol(B,13) ^ rol(B,23).
REQ-012 SHALL instantiate the team's combinational SMS4 S-box module exactly once and time-multiplex it over the 4 bytes, byte 0 first.
REQ-013 SHALL use FSM states IDLE, SUB, LIN, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; on in_valid=1 the block SHALL register x0, the XOR word x1^x2^x3^rk and the mode, clear byte index to 0, and go to SUB.
REQ-015 In SUB, each cycle SHALL substitute byte[index] into a 32-bit result register and increment the index; after index 3 it SHALL go to LIN (4 cycles in SUB).
REQ-016 In LIN, in one cycle it SHALL apply L or L', XOR with the registered x0, load x4, set out_valid, and go to DONE.
REQ-017 out_valid SHALL rise exactly 6 rising edges after the accepting edge (acceptance edge, 4 SUB edges, 1 LIN edge).
REQ-018 In DONE, out_valid=1 and x4 SHALL hold stable until out_ready=1; on that edge out_valid SHALL drop and the FSM SHALL go to IDLE.
REQ-019 in_ready SHALL be 0 in SUB, LIN and DONE; in_valid there SHALL be ignored, with no buffering.
REQ-020 Inputs x0..x3, rk and key_mode SHALL be sampled only on the accepting edge; later changes SHALL NOT affect the result.
REQ-021 out_ready SHALL be ignored outside DONE.
REQ-022 Byte index SHALL be 2 bits and wrap 3->0 on leaving SUB.

Reset
REQ-023 rst=1 at any edge SHALL force IDLE, in_ready=1, out_valid=0, x4=32'h0, byte index 0 and clear the internal registers.
REQ-024 rst SHALL take priority over all handshake inputs, including mid-SUB and DONE; an in-flight operation SHALL be discarded.
REQ-025 The first acceptance SHALL be possible on the first edge after rst deasserts.

Configuration
REQ-026 Macro SMS4_KEY_MODE_EN SHALL control the key-expansion feature.
REQ-027 With SMS4_KEY_MODE_EN defined, the key_mode port SHALL exist and select L' when 1.
REQ-028 Without SMS4_KEY_MODE_EN, key_mode SHALL be absent and L SHALL always be used; latency is unchanged.

Verification
REQ-029 Standard vector: x0..x3 = 01234567, 89abcdef, fedcba98, 76543210; rk = f12186f9; key_mode=0 -> x4 = 27fad345, out_valid 6 edges after acceptance.
REQ-030 All-zero inputs, key_mode=0 -> x4 = 5b5b5b5b; with key_mode=1 (macro defined) -> x4 = 67676767.
REQ-031 Backpressure: out_ready=0 for 10 cycles after out_valid -> x4 and out_valid stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge, and a new vector is accepted the following edge.
REQ-032 Change x1 and rk during SUB -> result still equals the REQ-029 value; in_valid pulses during SUB/DONE are not accepted.
REQ-033 Assert rst during the 3rd SUB cycle -> next edge out_valid=0, in_ready=1, x4=0; a fresh REQ-029 run then yields 27fad345.
REQ-034 Back-to-back: in_valid held high and out_ready tied 1 -> one result per 7 cycles, with each result matching a golden model.
